// File: rtl/triangle_pkg.sv
// Shared types and default sizes for the TRIANGLE host-side feeder.
//   state_t  : feeder FSM states
//   vertex_t : one (x, y) vertex at the default coordinate width
package triangle_pkg;

  localparam int unsigned CW_DEF      = 5;
  localparam int unsigned RW_DEF      = 13;
  localparam int unsigned NBEAT_DEF   = 3;
  localparam int unsigned TIMEOUT_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    COLLECT,
    HOLD
  } state_t;

  typedef struct packed {
    logic [CW_DEF-1:0] x;
    logic [CW_DEF-1:0] y;
  } vertex_t;

endpackage

// File: rtl/tri_watchdog.sv
// Saturating cycle counter that guards the wait for TRIANGLE results.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : load the count with zero (has priority over en)
//   en         : count one cycle, saturating at LIMIT
//   expired    : the count reaches LIMIT on the coming edge
module tri_watchdog #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count < W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // Looking one count ahead lets the registered FSM land in HOLD exactly
  // LIMIT cycles after the count started from zero.
  always_comb begin
    expired = en && (count >= W'(LIMIT - 1));
  end

endmodule

// File: rtl/triangle_feeder.sv
// Host-side driver for the TRIANGLE core: serialises one triangle onto the
// in_valid/coord stream and gathers the NBEAT-beat result into one word.
//   tri_valid/tri_ready/tri_x/tri_y : upstream triangle handshake (vertex k at [k*CW +: CW])
//   in_valid/coord_x/coord_y        : vertex stream to TRIANGLE
//   out_valid/out_length/out_incenter : result beats from TRIANGLE
//   res_valid/res_ready             : downstream result handshake
//   res_length/res_incenter         : packed beats (beat k at [k*RW +: RW])
//   res_timeout/res_proto_err       : abort and protocol-violation flags
module triangle_feeder
  import triangle_pkg::*;
#(
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned RW      = RW_DEF,
  parameter int unsigned NBEAT   = NBEAT_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tri_valid,
  output logic                tri_ready,
  input  logic [3*CW-1:0]     tri_x,
  input  logic [3*CW-1:0]     tri_y,
  output logic                in_valid,
  output logic [CW-1:0]       coord_x,
  output logic [CW-1:0]       coord_y,
  input  logic                out_valid,
  input  logic [RW-1:0]       out_length,
  input  logic [RW-1:0]       out_incenter,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NBEAT*RW-1:0] res_length,
  output logic [NBEAT*RW-1:0] res_incenter,
  output logic                res_timeout,
  output logic                res_proto_err
);

  localparam int unsigned BW = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  state_t          state;
  logic [3*CW-1:0] vx;
  logic [3*CW-1:0] vy;
  logic [1:0]      vidx;   // next vertex to present while in SEND
  logic [BW-1:0]   bidx;   // next result beat slot
  logic            wd_clr;
  logic            wd_en;
  logic            wd_expired;

  // The watchdog only runs while results are awaited and restarts on every beat.
  always_comb begin
    wd_clr = !((state == WAIT) || (state == COLLECT)) || out_valid;
    wd_en  = !wd_clr;
  end

  tri_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vx            <= '0;
      vy            <= '0;
      vidx          <= '0;
      bidx          <= '0;
      tri_ready     <= 1'b0;
      in_valid      <= 1'b0;
      coord_x       <= '0;
      coord_y       <= '0;
      res_valid     <= 1'b0;
      res_length    <= '0;
      res_incenter  <= '0;
      res_timeout   <= 1'b0;
      res_proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tri_ready <= 1'b1;
          if (tri_valid && tri_ready) begin
            vx            <= tri_x;
            vy            <= tri_y;
            tri_ready     <= 1'b0;
            in_valid      <= 1'b1;
            coord_x       <= tri_x[CW-1:0];
            coord_y       <= tri_y[CW-1:0];
            vidx          <= 2'd1;
            bidx          <= '0;
            res_length    <= '0;
            res_incenter  <= '0;
            res_timeout   <= 1'b0;
            // A stray beat on the capture cycle still belongs to this transaction.
            res_proto_err <= out_valid;
            state         <= SEND;
          end else if (out_valid) begin
            res_proto_err <= 1'b1;
          end
        end

        SEND: begin
          if (out_valid) res_proto_err <= 1'b1;
          if (vidx == 2'd3) begin
            in_valid <= 1'b0;
            coord_x  <= '0;
            coord_y  <= '0;
            state    <= WAIT;
          end else begin
            coord_x <= vx[vidx*CW +: CW];
            coord_y <= vy[vidx*CW +: CW];
            vidx    <= vidx + 2'd1;
          end
        end

        WAIT, COLLECT: begin
          if (out_valid) begin
            res_length[bidx*RW +: RW]   <= out_length;
            res_incenter[bidx*RW +: RW] <= out_incenter;
            if (bidx == BW'(NBEAT - 1)) begin
              res_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              bidx  <= bidx + 1'b1;
              state <= COLLECT;
            end
          end else begin
            if (state == COLLECT) res_proto_err <= 1'b1;
            if (wd_expired) begin
              res_valid   <= 1'b1;
              res_timeout <= 1'b1;
              state       <= HOLD;
            end
          end
        end

        HOLD: begin
          if (out_valid) res_proto_err <= 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            tri_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/triangle_feeder.md
Name: triangle_feeder

Overview:
- Host-side driver for the TRIANGLE core's coordinate/result interface.
- Accepts one triangle (three 5-bit vertices) over a valid/ready handshake and serialises it onto TRIANGLE's in_valid/coord_x/coord_y stream.
- Collects the out_valid/out_length/out_incenter beat train and presents one packed result word with a valid/ready handshake.
- Sits between the system controller and u_TRIANGLE; one triangle is in flight at a time.

Parameters:
- CW, 5, coordinate width (matches coord_x/coord_y)
- RW, 13, result beat width (matches out_length/out_incenter)
- NBEAT, 3, out_valid beats per triangle
- TIMEOUT, 1000, maximum cycles in WAIT before aborting (counter width = $clog2(TIMEOUT+1))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- tri_valid  in  1  upstream triangle valid
- tri_ready  out  1  feeder can accept a triangle
- tri_x  in  3*CW  vertex x; vertex k at [k*CW +: CW]
- tri_y  in  3*CW  vertex y; same packing as tri_x
- in_valid  out  1  to TRIANGLE
- coord_x  out  CW  to TRIANGLE
- coord_y  out  CW  to TRIANGLE
- out_valid  in  1  from TRIANGLE
- out_length  in  RW  from TRIANGLE
- out_incenter  in  RW  from TRIANGLE
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_length  out  NBEAT*RW  beat k at [k*RW +: RW]
- res_incenter  out  NBEAT*RW  beat k at [k*RW +: RW]
- res_timeout  out  1  result aborted by timeout (payload zero)
- res_proto_err  out  1  protocol violation seen during this transaction

Behaviour:
- Reset (async, rst_n=0): state IDLE; tri_ready=0, in_valid=0, coord_x/coord_y=0, res_valid=0, res_length/res_incenter=0, res_timeout=0, res_proto_err=0, counters=0. All outputs are registered.
- IDLE: tri_ready=1.
  - tri_valid&tri_ready: capture tri_x/tri_y and clear the error flag; go to SEND next cycle with beat index 0.
- SEND: 3 cycles.
  - in_valid=1 each cycle; coord_x/coord_y = vertex 0, 1, 2 in order.
  - in_valid is high for exactly 3 consecutive cycles; coord_* = 0 whenever in_valid=0.
  - After vertex 2, go to WAIT. tri_ready=0 in every state except IDLE.
- WAIT:
  - Cycle counter starts at 0 on entry and increments each cycle.
  - out_valid=1: store beat 0 and go to COLLECT.
  - Counter reaches TIMEOUT with no out_valid: go to HOLD with res_timeout=1 and payload zeroed.
- COLLECT: each out_valid=1 cycle stores beat k and increments k.
  - After beat NBEAT-1 is stored, go to HOLD.
  - out_valid=0 before NBEAT beats: set res_proto_err; keep waiting (the gap is tolerated); the WAIT-style timeout counter runs and restarts on each received beat.
  - Timeout in COLLECT: HOLD with res_timeout=1; beats already received are kept.
- HOLD: res_valid=1; payload and flags stay stable until res_ready=1.
  - The handshake completes on the cycle res_valid&res_ready, then go to IDLE.
  - res_valid falls the cycle after acceptance.
- out_valid=1 while in IDLE, SEND or HOLD: ignored as data. It sets the res_proto_err of the current or next transaction (the flag is sticky until the next capture clears it).
- Latency: tri accept at cycle t → in_valid cycles t+1..t+3 → first out_valid sampled → res_valid the cycle after the last beat is sampled.
- res_ready=1 while res_valid=0 has no effect.
- Reset mid-operation returns to IDLE immediately. Partial results are discarded and in_valid drops asynchronously.
- Widths: all payload is stored verbatim with no arithmetic. Counters saturate and never wrap.

Decomposition:
- Package triangle_pkg:
  - state enum {IDLE, SEND, WAIT, COLLECT, HOLD}
  - CW/RW/NBEAT defaults
  - vertex struct {x,y}
- One natural sub-module, tri_watchdog: a loadable saturating counter with clear/enable inputs and an expired output.
- Serialiser and collector stay in the top FSM.

Test Plan:
- Basic:
  - Stimulus: triangle (0,0),(4,0),(0,3); TRIANGLE model returns lengths 4,5,3 and incenter beats 1,1,0.
  - Required: in_valid high exactly 3 cycles with coords (0,0),(4,0),(0,3); res_length packs {3,5,4}; res_incenter packs {0,1,1}; res_timeout=0; res_proto_err=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles after res_valid.
  - Required: payload stable; tri_ready=0 throughout; accept on cycle 11; tri_ready=1 the next cycle.
- Timeout:
  - Stimulus: model never asserts out_valid.
  - Required: res_valid exactly TIMEOUT cycles after WAIT entry; res_timeout=1; payloads all zero.
- Gap:
  - Stimulus: out_valid beats 1 and 2 separated by 2 idle cycles.
  - Required: all 3 beats captured correctly; res_proto_err=1.
- Spurious:
  - Stimulus: out_valid pulse during SEND.
  - Required: beat not stored; res_proto_err=1 on that transaction.
- Reset mid-SEND:
  - Stimulus: rst_n low after vertex 1.
  - Required: in_valid=0 and coords=0 immediately; tri_ready=1 the first cycle after release; a fresh triangle then completes normally.
